conv3x3_stream: RTL and testbench

Streaming 3×3 convolution engine for the image-transform datapath, and the successor to the memory-based frame convolution core. It accepts one raster-ordered frame of unsigned pixels over a valid/ready stream and buffers two rows internally. It emits one filtered pixel per input pixel over a valid/ready stream, with zero padding at the borders, arithmetic normalisation, and a selectable output mode (signed saturate or pixel clamp). Frame dimensions, pixel width, coefficient width and output width are all parametrised.

---
 rtl/conv_pkg.sv | 11 +
 rtl/conv_line_buffer.sv | 24 ++
 rtl/conv3x3_stream.sv | 132 +++++++++++++
 tb/tb_conv3x3_stream.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types, constants and width helpers for the 3x3 streaming convolution
package conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic CLAMP_SAT = 1'b0;
  localparam logic CLAMP_PIX = 1'b1;
  localparam int COEF_MAX_W = 16;
  typedef logic signed [COEF_MAX_W-1:0] coef_arr_t [9];
  function automatic int acc_w(input int pix_w, input int coef_w);
    return pix_w + coef_w + 5;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two-row circular store addressed by column; returns the same column one and two rows back
module conv_line_buffer #(
  parameter int DEPTH = 129,
  parameter int AW = 8,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  row1,
  output logic [W-1:0]  row2
);
  logic [W-1:0] mem1 [DEPTH];
  logic [W-1:0] mem2 [DEPTH];
  assign row1 = mem1[addr];
  assign row2 = mem2[addr];
  always_ff @(posedge clk) begin
    if (en) begin
      mem1[addr] <= wdata;
      mem2[addr] <= mem1[addr];
    end
  end
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming zero-padded 3x3 correlation with shift normalisation and saturate/clamp output
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [9*COEF_W-1:0]   kernel,
  input  logic [3:0]            norm_shift,
  input  logic                  clamp_mode,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_W-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  localparam int ACC_W = acc_w(PIX_W, COEF_W);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'({(OUT_W-1){1'b1}});
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'({PIX_W{1'b1}});
  state_t state, state_nx;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  coef_arr_t coef;
  logic [3:0] nshift;
  logic cmode, en, real_step, step, last_step, fin, accept;
  logic [PIX_W-1:0] val, lb1, lb2;
  logic [PIX_W-1:0] win [3][3];
  logic [2:0] rok, cok;
  logic v1, last1;
  logic signed [ACC_W-1:0] sum, shifted, res;
  assign en = !(m_valid && !m_ready);
  assign real_step = (r < RW'(IMG_H)) && (c < CW'(IMG_W));
  assign step = state == RUN && en && (!real_step || s_valid);
  assign s_ready = state == RUN && en && real_step;
  assign last_step = r == RW'(IMG_H) && c == CW'(IMG_W);
  assign fin = state == DRAIN && m_valid && m_ready && m_last;
  assign accept = state == IDLE && start && !done;
  assign busy = state != IDLE || done;
  assign val = real_step ? s_data : '0;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? RUN : IDLE;
    else if (state == RUN) state_nx = (step && last_step) ? DRAIN : RUN;
    else state_nx = fin ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      done <= 1'b0;
      nshift <= '0;
      cmode <= CLAMP_SAT;
      coef <= '{default: '0};
    end else begin
      state <= state_nx;
      done <= fin;
      if (accept) begin
        for (int i = 0; i < 9; i++) coef[i] <= COEF_MAX_W'($signed(kernel[i*COEF_W +: COEF_W]));
        nshift <= norm_shift;
        cmode <= clamp_mode;
        r <= '0;
        c <= '0;
      end else if (step) begin
        c <= (c == CW'(IMG_W)) ? '0 : c + 1'b1;
        r <= (c == CW'(IMG_W)) ? r + 1'b1 : r;
      end
    end
  end
  conv_line_buffer #(.DEPTH(IMG_W + 1), .AW(CW), .W(PIX_W)) u_lb (
    .clk(clk), .en(step), .addr(c), .wdata(val), .row1(lb1), .row2(lb2)
  );
  // window columns are c-2..c and rows r-2..r; the centre is the output pixel
  always_ff @(posedge clk) begin
    if (step) begin
      for (int k = 0; k < 3; k++) begin
        win[k][0] <= win[k][1];
        win[k][1] <= win[k][2];
      end
      win[0][2] <= lb2;
      win[1][2] <= lb1;
      win[2][2] <= val;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
      last1 <= 1'b0;
      rok <= '0;
      cok <= '0;
    end else if (en) begin
      v1 <= step && r != '0 && c != '0;
      last1 <= step && last_step;
      if (step) begin
        rok <= {r < RW'(IMG_H), 1'b1, r >= RW'(2)};
        cok <= {c < CW'(IMG_W), 1'b1, c >= CW'(2)};
      end
    end
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++)
      sum = sum + ACC_W'(coef[i]) * $signed(ACC_W'((rok[i/3] && cok[i%3]) ? win[i/3][i%3] : '0));
    shifted = sum >>> nshift;
    res = cmode == CLAMP_PIX ? (shifted < 0 ? '0 : shifted > PMAX ? PMAX : shifted)
                             : (shifted > SMAX ? SMAX : shifted < SMIN ? SMIN : shifted);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (en) begin
      m_valid <= v1;
      m_last <= v1 && last1;
      if (v1) m_data <= OUT_W'(res);
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed 4x4 frames checked through an expected-value queue and an output monitor
module tb_conv3x3_stream;
  logic clk, rstn, start, clamp_mode, s_valid, s_ready, m_valid, m_ready, m_last, busy, done;
  logic [71:0] kernel;
  logic [3:0] norm_shift;
  logic [7:0] s_data;
  logic [11:0] m_data;
  int n_chk = 0, n_fail = 0;
  bit sb_off = 0, rand_ready = 0, exp_done = 0, holding = 0;
  logic [12:0] exp_q [$];
  logic [12:0] held, e;
  logic [7:0] px [16];
  logic [12:0] ex [16];
  int kk [9];

  conv3x3_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .COEF_W(8), .OUT_W(12)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kernel(kernel), .norm_shift(norm_shift),
    .clamp_mode(clamp_mode), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk);
      #1 m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      holding = 0;
      exp_done = 0;
    end else begin
      if (exp_done) begin
        n_chk++;
        if (!(done && busy)) begin
          n_fail++;
          $display("FAIL done_pulse: done=%0b busy=%0b, required 1/1", done, busy);
        end
        exp_done = 0;
      end
      if (holding) begin
        n_chk++;
        if ({m_valid, m_last, m_data} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b %h, required v=1 %h", m_valid, {m_last, m_data}, held);
        end
        holding = 0;
      end
      if (m_valid && !m_ready) begin
        holding = 1;
        held = {m_last, m_data};
      end
      if (m_valid && m_ready && !sb_off) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h, required no output", {m_last, m_data});
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            n_fail++;
            $display("FAIL out_beat: got last=%0b data=%h, required last=%0b data=%h", m_last, m_data, e[12], e[11:0]);
          end
          if (m_last) exp_done = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exv);
    end
  endtask

  function automatic logic [71:0] pack9();
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[i*8 +: 8] = 8'(kk[i]);
    return p;
  endfunction

  task automatic run_frame(input logic [3:0] sh, input logic md, input bit gaps, input int mid_start, input int abort_at);
    int idx = 0, guard = 0;
    bit hs;
    if (abort_at < 0) for (int i = 0; i < 16; i++) exp_q.push_back(ex[i]);
    kernel = pack9();
    norm_shift = sh;
    clamp_mode = md;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    while (idx < 16 && guard < 400) begin
      if (idx == abort_at) begin
        rstn = 0;
        s_valid = 0;
        @(posedge clk);
        #1 chk("reset_outputs", {26'd0, s_ready, m_valid, m_last, busy, done, |m_data}, 32'd0);
        rstn = 1;
        hs = 0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          hs = hs | done | m_valid | busy;
        end
        chk("no_done_after_abort", 32'(hs), 32'd0);
        @(posedge clk);
        #1;
        break;
      end
      start = (idx == mid_start);
      if (start) begin
        kernel = ~kernel;
        clamp_mode = ~clamp_mode;
        norm_shift = norm_shift + 4'd3;
      end
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = px[idx];
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1 if (hs) idx++;
      guard++;
    end
    start = 0;
    s_valid = 0;
    if (guard >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL input_timeout: accepted %0d pixels, required 16", idx);
    end
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 400) begin
      @(posedge clk);
      #1 guard++;
    end
    if (guard >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic setup_ramp();
    kk = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      px[i] = 8'(i);
      ex[i] = {i == 15, 12'(i)};
    end
  endtask

  initial begin
    int t2 [16] = '{40, 60, 60, 40, 60, 90, 90, 60, 60, 90, 90, 60, 40, 60, 60, 40};
    rstn = 0;
    start = 0;
    s_valid = 0;
    s_data = 0;
    kernel = 0;
    norm_shift = 0;
    clamp_mode = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset_in_reset", {26'd0, s_ready, m_valid, m_last, busy, done, |m_data}, 32'd0);
    rstn = 1;
    @(negedge clk);
    chk("reset_after_release", {26'd0, s_ready, m_valid, m_last, busy, done, |m_data}, 32'd0);
    @(posedge clk);
    #1;
    setup_ramp();
    run_frame(4'd0, 1'b0, 0, -1, -1);
    kk = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 16; i++) begin
      px[i] = 8'd10;
      ex[i] = {i == 15, 12'(t2[i])};
    end
    run_frame(4'd0, 1'b0, 0, 6, -1);
    kk = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    for (int i = 0; i < 16; i++) begin
      px[i] = 8'd255;
      ex[i] = {i == 15, 12'h7FF};
    end
    run_frame(4'd0, 1'b0, 0, -1, -1);
    kk = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    for (int i = 0; i < 16; i++) ex[i] = {i == 15, 12'h000};
    run_frame(4'd1, 1'b1, 0, -1, -1);
    setup_ramp();
    rand_ready = 1;
    run_frame(4'd0, 1'b0, 1, 5, -1);
    rand_ready = 0;
    sb_off = 1;
    run_frame(4'd0, 1'b0, 0, -1, 7);
    sb_off = 0;
    run_frame(4'd0, 1'b0, 0, -1, -1);
    kk = '{0, 0, 0, -9, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      px[i] = (i == 5) ? 8'd1 : 8'd0;
      ex[i] = {i == 15, (i == 6) ? 12'hFFB : 12'h000};
    end
    run_frame(4'd1, 1'b0, 0, -1, -1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
